// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// The enum, widths and negation helper are used by the divider controller.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  // Widest operand the negation helper supports; callers zero-extend and truncate.
  localparam int TWOS_W    = 64;

  function automatic logic [TWOS_W-1:0] twos_neg(input logic [TWOS_W-1:0] v);
    return ~v + TWOS_W'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step on {rem, quo}.
// The remainder entering a step is always below the divisor, so WIDTH+2 bits hold the trial.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_fits;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {2'b00, i_divisor};
  assign w_fits  = ~w_trial[WIDTH+1];

  assign o_rem = w_fits ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/mdu_div_ctrl.sv
// Iterative DIV/DIVU controller: sign handling, restoring loop, stall and HI/LO result registers.
// Handshake: start is taken when busy=0; done pulses one cycle with q_out/r_out valid from then on.
module mdu_div_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk_sig,
  input  logic             rst_sig,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output div_state_t       dbg_state
);

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] r_abs_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic             w_signed;
  logic             w_b_zero;
  logic             w_accept;
  logic             w_last;

  assign w_signed = ~is_unsigned;
  assign w_b_zero = (op_b == '0);
  assign busy     = (r_state == CALC) || (r_state == FIX);
  assign w_accept = start & ~busy;
  assign stall    = busy | (w_accept & ~w_b_zero);
  assign done     = (r_state == DONE);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_abs_a = (w_signed & op_a[WIDTH-1]) ? WIDTH'(twos_neg(TWOS_W'(op_a))) : op_a;
  assign w_abs_b = (w_signed & op_b[WIDTH-1]) ? WIDTH'(twos_neg(TWOS_W'(op_b))) : op_b;
  // Final remainder is below |b| so its top bit is always clear here.
  assign w_q_fix = r_neg_q ? WIDTH'(twos_neg(TWOS_W'(r_quo))) : r_quo;
  assign w_r_fix = r_neg_r ? WIDTH'(twos_neg(TWOS_W'(r_rem[WIDTH-1:0]))) : r_rem[WIDTH-1:0];

  assign div_by_zero = r_dbz;
  assign q_out       = r_q_out;
  assign r_out       = r_r_out;
  assign dbg_state   = r_state;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_abs_b),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start)              w_next_state = w_b_zero ? DONE : CALC;
        else                    w_next_state = IDLE;
      end
      CALC:    if (w_last)      w_next_state = FIX;
      FIX:                      w_next_state = DONE;
      default:                  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_abs_b <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else if (w_accept) begin
      r_rem   <= '0;
      r_quo   <= w_abs_a;
      r_abs_b <= w_abs_b;
      r_cnt   <= '0;
      r_neg_q <= w_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      r_neg_r <= w_signed & op_a[WIDTH-1];
      r_dbz   <= w_b_zero;
      if (w_b_zero) begin
        r_q_out <= '1;
        r_r_out <= op_a;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_step_rem;
      r_quo <= w_step_quo;
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == FIX) begin
      r_q_out <= w_q_fix;
      r_r_out <= w_r_fix;
    end
  end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Directed bench for mdu_div_ctrl: signed/unsigned division, overflow, divide by zero,
// start while busy, back-to-back accept and asynchronous reset mid-iteration.
module tb_mdu_div_ctrl;
  import mdu_pkg::*;

  logic        clk_sig = 1'b0;
  logic        rst_sig = 1'b1;
  logic        start = 1'b0;
  logic        is_unsigned = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_by_zero;
  logic [31:0] q_out;
  logic [31:0] r_out;
  div_state_t  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_sig = ~clk_sig;

  mdu_div_ctrl dut (
    .clk_sig     (clk_sig),
    .rst_sig     (rst_sig),
    .start       (start),
    .is_unsigned (is_unsigned),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_by_zero (div_by_zero),
    .q_out       (q_out),
    .r_out       (r_out),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to done. lat counts rising edges after the accept edge.
  task automatic run_div(input string tag, input logic u, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat, input int ebusy,
                         input bit b2b, input int poke, input bit pulse_chk);
    int  k;
    int  nbusy;
    bit  seen;
    if (!b2b) @(negedge clk_sig);
    is_unsigned = u;
    op_a        = a;
    op_b        = b;
    start       = 1'b1;
    #1;
    chk({tag, "_stall_acc"}, 32'(stall), 32'(b != 32'h0));
    chk({tag, "_busy_acc"}, 32'(busy), 32'h0);
    @(posedge clk_sig);
    #1;
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h0000_0000;
    k     = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk_sig);
      k++;
      if (k == poke) begin
        start       = 1'b1;
        is_unsigned = ~u;
        op_a        = 32'h0000_0005;
        op_b        = 32'h0000_0001;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'h1);
    chk({tag, "_latency"}, 32'(k - 1), 32'(elat));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(ebusy));
    chk({tag, "_q"}, q_out, eq);
    chk({tag, "_r"}, r_out, er);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    if (pulse_chk) begin
      @(negedge clk_sig);
      chk({tag, "_done_pulse"}, 32'(done), 32'h0);
      chk({tag, "_q_held"}, q_out, eq);
      chk({tag, "_r_held"}, r_out, er);
    end
  endtask

  initial begin
    int done_glitches;

    // Reset state
    repeat (2) @(negedge clk_sig);
    chk("rst_q", q_out, 32'h0);
    chk("rst_r", r_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_sig = 1'b0;
    @(negedge clk_sig);
    chk("idle_state", 32'(dbg_state), 32'(IDLE));

    // Main function
    run_div("divu_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 33, 1'b0, 0, 1'b1);
    run_div("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 33,
            1'b0, 0, 1'b1);
    run_div("div_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 33,
            1'b0, 0, 1'b1);
    // Overflow case, then the unsigned form accepted in the DONE cycle
    run_div("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33, 33,
            1'b0, 0, 1'b0);
    run_div("divu_ovf_b2b", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 33,
            1'b1, 0, 1'b1);
    run_div("div_by_zero", 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0, 0,
            1'b0, 0, 1'b1);
    // Start re-asserted mid-CALC must not disturb 1000/7
    run_div("divu_poke", 1'b1, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 33, 33, 1'b0, 5, 1'b1);

    // Asynchronous reset at CALC step 10
    @(negedge clk_sig);
    is_unsigned = 1'b1;
    op_a        = 32'd50;
    op_b        = 32'd3;
    start       = 1'b1;
    @(posedge clk_sig);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk_sig);
    chk("mid_calc_state", 32'(dbg_state), 32'(CALC));
    chk("mid_calc_busy", 32'(busy), 32'h1);
    rst_sig = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_q", q_out, 32'h0);
    chk("arst_r", r_out, 32'h0);
    chk("arst_dbz", 32'(div_by_zero), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk_sig);
    rst_sig = 1'b0;
    done_glitches = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sig);
      if (done || busy) done_glitches++;
    end
    chk("arst_no_done", 32'(done_glitches), 32'h0);
    run_div("divu_9_3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 33, 1'b0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_div_ctrl.md
# mdu_div_ctrl

Sequential controller for the CPU's DIV/DIVU path. It replaces the single-cycle combinational division array with an iterative radix-2 restoring divider that retires one quotient bit per clock. It owns the start/busy/done handshake, the pipeline stall, operand sign handling and the result registers. It sits between the decode/execute stage and the HI/LO write-back: quotient goes to LO and remainder goes to HI.

## Interface
- Parameter `WIDTH`, default 32: operand, quotient and remainder width.
- Parameter `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.
- `clk_sig`, in, 1: sole clock; all state updates on the rising edge.
- `rst_sig`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request a division; sampled only when `busy`=0.
- `is_unsigned`, in, 1: 1 selects DIVU, 0 selects DIV (signed); sampled together with `start`.
- `op_a`, in, WIDTH: dividend; sampled together with `start`.
- `op_b`, in, WIDTH: divisor; sampled together with `start`.
- `busy`, out, 1: operation in progress; new `start` is ignored.
- `stall`, out, 1: pipeline hold, combinational = `busy` | (`start` & ~`busy` & `op_b`≠0).
- `done`, out, 1: one-cycle pulse; `q_out`/`r_out` are valid from this cycle on.
- `div_by_zero`, out, 1: registered with `done`; set when the accepted `op_b` was 0.
- `q_out`, out, WIDTH: quotient register, held until the next accepted `start`.
- `r_out`, out, WIDTH: remainder register, held until the next accepted `start`.

## Operation
- States are IDLE, CALC, FIX and DONE. `busy` = (state ∈ {CALC, FIX}).
- **IDLE/DONE with `start`=1:**
  - Latch `is_unsigned`.
  - Latch the magnitudes |op_a| and |op_b|. Two's-complement negation is applied only when the operation is signed and the MSB is set.
  - Latch `neg_q` = signed & (a[MSB] ^ b[MSB]) and `neg_r` = signed & a[MSB].
  - Clear the partial remainder (WIDTH+1 bits), load the quotient shift register with |op_a|, clear the counter, and go to CALC.
  - If `op_b` = 0, go to DONE instead. This sets q = all-ones, r = `op_a` unmodified, `div_by_zero` = 1.
- **IDLE with `start`=0:** stay in IDLE.
- **DONE with `start`=0:** go to IDLE.
- **CALC, each cycle (one restoring step):**
  - Form {rem, quo} shifted left by 1.
  - trial = rem − |b|.
  - If trial ≥ 0: rem = trial and the new quo LSB = 1. Otherwise rem is kept and the LSB = 0.
  - Counter increments. After step WIDTH−1 (counter = WIDTH−1), go to FIX.
- **FIX (one cycle):**
  - q = `neg_q` ? −quo : quo.
  - r = `neg_r` ? −rem : rem.
  - Both are written to `q_out`/`r_out`. Go to DONE.
- **DONE:** `done`=1 for this single cycle, then IDLE (or a new operation if `start`=1).
- **Arithmetic rules:**
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case 0x80000000 / −1 (signed) gives q = 0x80000000, r = 0, with no flag.
  - All negation is modulo 2^WIDTH.
- **`start` while `busy`:** ignored; the operation in flight is unaffected.
- **Reset:** asynchronous at any time, including mid-CALC.
  - State returns to IDLE.
  - `busy`, `done`, `div_by_zero` = 0.
  - `q_out`, `r_out` = 0.
  - Counter and internal registers are cleared.

## Timing
- Reset values: every output is 0. `stall` is 0 provided `start`=0.
- Normal latency: `start` is sampled at edge E0, `done` is high in the cycle following edge E0+WIDTH+1. That is 33 edges for WIDTH=32, and `busy` is high for WIDTH+1 cycles.
- Divide-by-zero latency: `done` is high in the cycle following E0; `busy` never rises.
- Back-to-back: `start` asserted in the DONE cycle is accepted, so there are no idle cycles between operations.
- `q_out`/`r_out` change only at the FIX→DONE edge, the divide-by-zero accept edge, or reset.

## Structure
- **Shared package `mdu_pkg`:**
  - state enum `div_state_t` {IDLE, CALC, FIX, DONE}
  - `DIV_WIDTH` = 32
  - `DIV_ITER` = 32
  - helper function `twos_neg`
- **Sub-module `div_step`:** purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside `mdu_div_ctrl`.
- The FSM, counter and result registers stay in `mdu_div_ctrl`.

## Test plan
- **Unsigned:** DIVU 100 / 7 → `done` in cycle E0+33; q = 14, r = 2; `busy` high for 33 cycles; `stall` high from the accept cycle until `done`.
- **Signed:** DIV 0xFFFFFFF9 (−7) / 2 → q = 0xFFFFFFFD (−3), r = 0xFFFFFFFF (−1).
- **Signed, negative divisor:** DIV 7 / 0xFFFFFFFE → q = 0xFFFFFFFD, r = 1.
- **Overflow and unsigned equivalent:**
  - DIV 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0.
  - The same operands with DIVU → q = 0, r = 0x80000000.
- **Divide by zero:** DIV 0x12345678 / 0 → `done` in cycle E0+1; q = 0xFFFFFFFF, r = 0x12345678, `div_by_zero` = 1; `busy` stays 0.
- **Reset and `start` while busy:**
  - Re-asserting `start` mid-CALC has no effect on the result or latency.
  - Asserting `rst_sig` at CALC step 10 drops all outputs to 0 immediately, with no `done` pulse.
  - The next DIVU 9 / 3 gives q = 3, r = 0.
